rob_order_tracker: RTL

ROB-side bookkeeping for renamed ops: consumes tags issued by the rename-stage tag allocator and records them in program order. It tracks completion and retires ops in order. It publishes the live-tag mask and ROB-insert feedback that the allocator uses to avoid tag reuse. Sits between rename/dispatch, the writeback bus and the commit stage.

---
 rtl/rob_order_tracker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rob_order_tracker.sv
// rob_order_tracker: program-order record of renamed ops. Tracks completion,
// retires in order, truncates on mispredict recovery and publishes the live-tag
// mask plus insert feedback that the rename-stage tag allocator relies on.
module rob_order_tracker #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 recover_i,
    input  logic [ROB_W-1:0]     recover_tag_i,
    input  logic                 alloc_valid_i,
    input  logic [ROB_W-1:0]     alloc_tag_i,
    output logic                 alloc_ready_o,
    output logic                 rob_alloc_fire_o,
    output logic [ROB_W-1:0]     rob_alloc_tag_o,
    output logic [ROB_DEPTH-1:0] live_tag_o,
    input  logic                 complete_valid_i,
    input  logic [ROB_W-1:0]     complete_tag_i,
    output logic                 commit_valid_o,
    output logic [ROB_W-1:0]     commit_tag_o,
    input  logic                 commit_ready_i,
    output logic [ROB_W:0]       count_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 dup_err_o
);

    localparam int PTR_W = ROB_W + 1;

    logic [ROB_W-1:0]     order_q [ROB_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ROB_DEPTH-1:0] live_q, live_d, done_q, done_d;
    logic                 dupErr_q, dupErr_d;

    logic [PTR_W-1:0]     count;
    logic                 empty, full, fire, commitFire;
    logic [ROB_W-1:0]     headTag;
    logic                 recFound, recApply;
    logic [PTR_W-1:0]     recOff;
    logic [ROB_W-1:0]     searchIdx, squashIdx;

    // Occupancy and handshake flags derived from the wrap-bit pointers.
    always_comb begin
        count      = tail_q - head_q;
        empty      = (head_q == tail_q);
        full       = (head_q[ROB_W-1:0] == tail_q[ROB_W-1:0]) && (head_q[ROB_W] != tail_q[ROB_W]);
        headTag    = order_q[head_q[ROB_W-1:0]];
        fire       = alloc_valid_i && !full && !flush_i && !recover_i;
        commitFire = !empty && done_q[headTag] && !flush_i && commit_ready_i;
    end

    // Locate the oldest in-flight entry holding the recovering tag.
    always_comb begin
        recFound  = 1'b0;
        recOff    = '0;
        searchIdx = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            searchIdx = head_q[ROB_W-1:0] + ROB_W'(i);
            if (!recFound && (PTR_W'(i) < count) && (order_q[searchIdx] == recover_tag_i)) begin
                recFound = 1'b1;
                recOff   = PTR_W'(i);
            end
        end
        recApply = recover_i && !flush_i && recFound && live_q[recover_tag_i];
    end

    // Next-state: complete, then commit, then squash (so a squash wins), then alloc.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        live_d    = live_q;
        done_d    = done_q;
        squashIdx = '0;
        dupErr_d  = dupErr_q | (fire && live_q[alloc_tag_i]);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            live_d = '0;
            done_d = '0;
        end else begin
            if (complete_valid_i && live_q[complete_tag_i]) begin
                done_d[complete_tag_i] = 1'b1;
            end
            if (commitFire) begin
                live_d[headTag] = 1'b0;
                done_d[headTag] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (recApply) begin
                tail_d = head_q + recOff + PTR_W'(1);
                for (int j = 0; j < ROB_DEPTH; j++) begin
                    squashIdx = head_q[ROB_W-1:0] + ROB_W'(j);
                    if ((PTR_W'(j) > recOff) && (PTR_W'(j) < count)) begin
                        live_d[order_q[squashIdx]] = 1'b0;
                        done_d[order_q[squashIdx]] = 1'b0;
                    end
                end
            end
            if (fire) begin
                live_d[alloc_tag_i] = 1'b1;
                done_d[alloc_tag_i] = 1'b0;
                tail_d              = tail_q + PTR_W'(1);
            end
        end
    end

    // State registers; the order FIFO slot at the tail is written on insert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            live_q   <= '0;
            done_q   <= '0;
            dupErr_q <= 1'b0;
            for (int k = 0; k < ROB_DEPTH; k++) begin
                order_q[k] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            live_q   <= live_d;
            done_q   <= done_d;
            dupErr_q <= dupErr_d;
            if (fire) begin
                order_q[tail_q[ROB_W-1:0]] <= alloc_tag_i;
            end
        end
    end

    // Output drive.
    always_comb begin
        alloc_ready_o    = !full;
        rob_alloc_fire_o = fire;
        rob_alloc_tag_o  = alloc_tag_i;
        live_tag_o       = live_q;
        commit_valid_o   = !empty && done_q[headTag] && !flush_i;
        commit_tag_o     = headTag;
        count_o          = count;
        empty_o          = empty;
        full_o           = full;
        dup_err_o        = dupErr_q;
    end

endmodule
